// File: rtl/alt_compressor_fsm_pkg.sv
// Shared state encoding and per-state output patterns for the compressor
// alternation controller.
package alt_compressor_fsm_pkg;

  typedef enum logic [2:0] {
    S_A = 3'd0,  // idle, next is C1
    S_B = 3'd1,  // C1 running
    S_C = 3'd2,  // idle, next is C2
    S_D = 3'd3,  // C2 running
    S_E = 3'd4,  // idle, next is C3
    S_F = 3'd5,  // C3 running
    S_G = 3'd6   // all running
  } state_t;

  localparam logic [2:0] OUT_A = 3'b000;
  localparam logic [2:0] OUT_B = 3'b100;
  localparam logic [2:0] OUT_D = 3'b010;
  localparam logic [2:0] OUT_F = 3'b001;
  localparam logic [2:0] OUT_G = 3'b111;

endpackage

// File: rtl/alt_compressor_fsm_outdec.sv
// Moore output decode: state to {C1,C2,C3}.
module alt_compressor_fsm_outdec
  import alt_compressor_fsm_pkg::*;
(
  input  state_t     state,
  output logic [2:0] run
);

  always_comb begin
    run = OUT_A;
    case (state)
      S_B:     run = OUT_B;
      S_D:     run = OUT_D;
      S_F:     run = OUT_F;
      S_G:     run = OUT_G;
      default: run = OUT_A;
    endcase
  end

endmodule

// File: rtl/alt_compressor_fsm.sv
// Alternates three compressors from PA/PB/PMB pressure switches; PMB forces
// all on until PA, after which rotation restarts at C1.
module alt_compressor_fsm
  import alt_compressor_fsm_pkg::*;
(
  input  logic Clk,
  input  logic Reset,
  input  logic PA,
  input  logic PB,
  input  logic PMB,
  output logic C1,
  output logic C2,
  output logic C3
);

  state_t     state;
  state_t     state_next;
  logic [2:0] run;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state <= S_A;
    else       state <= state_next;
  end

  // Strict priority PMB > PA > PB: a lower input is ignored whenever a higher one is asserted.
  always_comb begin
    state_next = state;
    case (state)
      S_A: if (PMB) state_next = S_G; else if (!PA && PB) state_next = S_B;
      S_B: if (PMB) state_next = S_G; else if (PA) state_next = S_C;
      S_C: if (PMB) state_next = S_G; else if (!PA && PB) state_next = S_D;
      S_D: if (PMB) state_next = S_G; else if (PA) state_next = S_E;
      S_E: if (PMB) state_next = S_G; else if (!PA && PB) state_next = S_F;
      S_F: if (PMB) state_next = S_G; else if (PA) state_next = S_A;
      S_G: if (!PMB && PA) state_next = S_A;
      default: state_next = S_A;
    endcase
  end

  alt_compressor_fsm_outdec u_outdec (
    .state (state),
    .run   (run)
  );

  assign {C1, C2, C3} = run;

endmodule

// File: tb/tb_alt_compressor_fsm.sv
// Directed-vector bench for alt_compressor_fsm with hand-computed outputs.
module tb_alt_compressor_fsm;

  logic Clk = 1'b0;
  logic Reset = 1'b0;
  logic PA = 1'b0;
  logic PB = 1'b0;
  logic PMB = 1'b0;
  logic C1, C2, C3;

  int checks = 0;
  int failures = 0;

  // Input vector encoding {PMB,PA,PB}
  localparam logic [2:0] IN_0   = 3'b000;
  localparam logic [2:0] IN_PB  = 3'b001;
  localparam logic [2:0] IN_PA  = 3'b010;
  localparam logic [2:0] IN_PMB = 3'b100;
  localparam logic [2:0] IN_PA_PMB = 3'b110;

  alt_compressor_fsm dut (
    .Clk   (Clk),
    .Reset (Reset),
    .PA    (PA),
    .PB    (PB),
    .PMB   (PMB),
    .C1    (C1),
    .C2    (C2),
    .C3    (C3)
  );

  always #5 Clk = ~Clk;

  task automatic check_eq(input string tag, input logic [2:0] got, input logic [2:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic do_reset(input string tag);
    @(negedge Clk);
    {PMB, PA, PB} = IN_0;
    Reset = 1'b1;
    #1;
    check_eq(tag, {C1, C2, C3}, 3'b000);
    Reset = 1'b0;
  endtask

  task automatic step(input string tag, input logic [2:0] vin, input logic [2:0] exp);
    @(negedge Clk);
    {PMB, PA, PB} = vin;
    @(posedge Clk);
    #1;
    check_eq(tag, {C1, C2, C3}, exp);
  endtask

  initial begin
    // Reset check
    do_reset("reset_async");
    step("reset_idle", IN_0, 3'b000);

    // Partial rotation
    do_reset("rst_partial");
    step("part_pb",   IN_PB,  3'b100);
    step("part_0",    IN_0,   3'b100);
    step("part_pmb",  IN_PMB, 3'b111);
    step("part_0b",   IN_0,   3'b111);
    step("part_pa",   IN_PA,  3'b000);

    // Emergency from C2
    do_reset("rst_emerg");
    step("em_pb",   IN_PB,  3'b100);
    step("em_pa",   IN_PA,  3'b000);
    step("em_0",    IN_0,   3'b000);
    step("em_pb2",  IN_PB,  3'b010);
    step("em_0b",   IN_0,   3'b010);
    step("em_pmb",  IN_PMB, 3'b111);
    step("em_pa2",  IN_PA,  3'b000);

    // Full rotation
    do_reset("rst_full");
    step("full_pb1", IN_PB,  3'b100);
    step("full_pa1", IN_PA,  3'b000);
    step("full_pb2", IN_PB,  3'b010);
    step("full_pa2", IN_PA,  3'b000);
    step("full_0a",  IN_0,   3'b000);
    step("full_pb3", IN_PB,  3'b001);
    step("full_0b",  IN_0,   3'b001);
    step("full_pmb", IN_PMB, 3'b111);
    step("full_pa3", IN_PA,  3'b000);

    // Rotation wrap, plus held-input behaviour
    do_reset("rst_wrap");
    step("wrap_pb1", IN_PB, 3'b100);
    step("wrap_pa1", IN_PA, 3'b000);
    step("wrap_pb2", IN_PB, 3'b010);
    step("wrap_pa2", IN_PA, 3'b000);
    step("wrap_pb3", IN_PB, 3'b001);
    step("wrap_pa3", IN_PA, 3'b000);
    step("wrap_pb4", IN_PB, 3'b100);
    step("hold_pb",  IN_PB, 3'b100);
    step("hold_pa",  IN_PA, 3'b000);
    step("hold_pa2", IN_PA, 3'b000);

    // Idle ignores PA; PMB from idle goes to g and holds while asserted
    do_reset("rst_idle");
    step("idle_pa",   IN_PA,  3'b000);
    step("idle_pmb",  IN_PMB, 3'b111);
    step("g_pmb",     IN_PMB, 3'b111);
    step("g_pb",      IN_PB,  3'b111);
    step("g_pa_pmb",  IN_PA_PMB, 3'b111);
    step("g_pa",      IN_PA,  3'b000);
    step("restart",   IN_PB,  3'b100);

    // Priority: PA and PMB together in b
    do_reset("rst_prio");
    step("prio_pb",  IN_PB,     3'b100);
    step("prio_b",   IN_PB,     3'b100);
    step("prio_both", IN_PA_PMB, 3'b111);

    // Asynchronous reset from state d between edges
    do_reset("rst_async2");
    step("ar_pb1", IN_PB, 3'b100);
    step("ar_pa1", IN_PA, 3'b000);
    step("ar_pb2", IN_PB, 3'b010);
    @(negedge Clk);
    {PMB, PA, PB} = IN_0;
    #2;
    Reset = 1'b1;
    #1;
    check_eq("async_mid", {C1, C2, C3}, 3'b000);
    Reset = 1'b0;
    step("after_ar", IN_PB, 3'b100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
